// File: rtl/funcion_sweep_capture_pkg.sv
// funcion_sweep_capture_pkg: shared FSM encoding and vector width for the sweep/capture stage
package funcion_sweep_capture_pkg;
  localparam int VEC_W = 5;
  typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_SETTLE, ST_SAMPLE, ST_FINISH} state_t;
endpackage

// File: rtl/funcion_sweep_capture_if.sv
// funcion_sweep_capture_if: start/done request bus and result outputs of the capture stage
interface funcion_sweep_capture_if;
  import funcion_sweep_capture_pkg::*;
  logic start;
  logic mode;
  logic [VEC_W-1:0] vec_in;
  logic busy;
  logic done;
  logic result;
  logic [31:0] table_out;
  logic [5:0] ones_count;
  modport master(output start, mode, vec_in, input busy, done, result, table_out, ones_count);
  modport slave(input start, mode, vec_in, output busy, done, result, table_out, ones_count);
endinterface

// File: rtl/funcion_sweep_capture_sop.sv
// funcion_sweep_capture_sop: 5-input SOP function F_Final, minterms {2,3,6,10,11,15,17,18,19,20,21,25,27}
module funcion_sweep_capture_sop (
  input  logic X,
  input  logic Y,
  input  logic Z,
  input  logic K,
  input  logic M,
  output logic F_Final
);
  localparam logic [31:0] MINTERMS = 32'h0A3E_8C4C;
  assign F_Final = MINTERMS[{X, Y, Z, K, M}];
endmodule

// File: rtl/funcion_sweep_capture.sv
// funcion_sweep_capture: drives X..M from registers, waits SETTLE cycles, samples F_in (single or 32-vector sweep)
module funcion_sweep_capture
  import funcion_sweep_capture_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  funcion_sweep_capture_if.slave bus,
  input  logic F_in,
  output logic X,
  output logic Y,
  output logic Z,
  output logic K,
  output logic M
);
  state_t state, nxt;
  logic [VEC_W-1:0] vec;
  logic mode_r;
  logic [3:0] cnt;
  logic accept;
  // the done cycle still belongs to the finishing run, so a start there is not taken
  assign accept = bus.start && !bus.done;
  // next-state sequencing
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:   nxt = accept ? ST_DRIVE : ST_IDLE;
      ST_DRIVE:  nxt = ST_SETTLE;
      ST_SETTLE: nxt = (cnt == 4'd0) ? ST_SAMPLE : ST_SETTLE;
      ST_SAMPLE: nxt = (!mode_r || vec == 5'd31) ? ST_FINISH : ST_DRIVE;
      ST_FINISH: nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end
  // state register, vector drive, sampling and result accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      vec            <= '0;
      mode_r         <= 1'b0;
      cnt            <= '0;
      {X, Y, Z, K, M} <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.result     <= 1'b0;
      bus.table_out  <= '0;
      bus.ones_count <= '0;
    end else begin
      state    <= nxt;
      bus.done <= state == ST_FINISH;
      unique case (state)
        ST_IDLE: if (accept) begin
          vec      <= bus.mode ? '0 : bus.vec_in;
          mode_r   <= bus.mode;
          bus.busy <= 1'b1;
          if (bus.mode) begin
            bus.table_out  <= '0;
            bus.ones_count <= '0;
          end
        end
        ST_DRIVE: begin
          {X, Y, Z, K, M} <= vec;
          cnt             <= 4'(SETTLE - 1);
        end
        ST_SETTLE: cnt <= cnt - 4'd1;
        ST_SAMPLE: begin
          bus.result <= F_in;
          if (mode_r) begin
            bus.table_out[vec] <= F_in;
            bus.ones_count     <= bus.ones_count + 6'(F_in);
            if (vec != 5'd31) vec <= vec + 5'd1;
          end
        end
        ST_FINISH: bus.busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_funcion_sweep_capture.sv
// tb_funcion_sweep_capture: directed stimulus with a schedule-based reference model checked every cycle
module tb_funcion_sweep_capture;
  localparam int S = 2;
  localparam int P = S + 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  funcion_sweep_capture_if bus();
  funcion_sweep_capture_if b1();
  funcion_sweep_capture_if b4();
  logic X, Y, Z, K, M, f_sop, F_in;
  logic sel = 1'b0;
  logic X1, Y1, Z1, K1, M1, X4, Y4, Z4, K4, M4;
  logic dl1;
  logic [3:0] dl4;
  funcion_sweep_capture_sop sop (.X(X), .Y(Y), .Z(Z), .K(K), .M(M), .F_Final(f_sop));
  assign F_in = sel ? f_sop : M;
  funcion_sweep_capture #(.SETTLE(S)) dut (
    .clk(clk), .reset(reset), .bus(bus), .F_in(F_in),
    .X(X), .Y(Y), .Z(Z), .K(K), .M(M));
  funcion_sweep_capture #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .F_in(dl1),
    .X(X1), .Y(Y1), .Z(Z1), .K(K1), .M(M1));
  funcion_sweep_capture #(.SETTLE(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4), .F_in(dl4[3]),
    .X(X4), .Y(Y4), .Z(Z4), .K(K4), .M(M4));
  // stub functions whose output lags the drive by exactly SETTLE cycles
  always @(posedge clk) begin
    dl1 <= M1;
    dl4 <= {dl4[2:0], M4};
  end
  int mts[13] = '{2, 3, 6, 10, 11, 15, 17, 18, 19, 20, 21, 25, 27};
  function automatic logic fexp(input int i);
    if (!sel) return i[0];
    foreach (mts[k]) if (mts[k] == i) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  bit m_act = 1'b0;
  bit m_mode = 1'b0;
  int m_t0 = 0;
  logic [4:0] m_vec = '0;
  logic [4:0] m_drv = '0;
  logic [31:0] m_tbl = '0;
  logic [5:0] m_ones = '0;
  logic m_res = 1'b0;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  initial begin : model
    logic rs, ss, ms, pd, b;
    logic [4:0] vs;
    int d, i;
    forever begin
      @(posedge clk);
      rs = reset; ss = bus.start; ms = bus.mode; vs = bus.vec_in;
      @(negedge clk);
      pd = m_done;
      m_done = 1'b0;
      if (rs) begin
        m_act = 0; m_drv = '0; m_tbl = '0; m_ones = '0; m_res = 0; m_busy = 0;
      end else if (m_act) begin
        d = cyc - m_t0;
        if (m_mode) begin
          if ((d - 1) % P == 0 && d - 1 < 32 * P) m_drv = 5'((d - 1) / P);
          if (d % P == 0 && d <= 32 * P) begin
            i = d / P - 1;
            b = fexp(i);
            m_tbl[i] = b;
            m_ones = m_ones + 6'(b);
            m_res = b;
          end
          if (d == 32 * P + 1) begin m_done = 1; m_busy = 0; m_act = 0; end
        end else begin
          if (d == 1) m_drv = m_vec;
          if (d == S + 2) m_res = fexp(int'(m_vec));
          if (d == S + 3) begin m_done = 1; m_busy = 0; m_act = 0; end
        end
      end else if (ss && !pd) begin
        m_act = 1; m_t0 = cyc; m_mode = ms; m_vec = vs; m_busy = 1;
        if (ms) begin m_tbl = '0; m_ones = '0; end
      end
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("result", bus.result, m_res);
      chk("table_out", bus.table_out, m_tbl);
      chk("ones_count", bus.ones_count, m_ones);
      chk("drive", {X, Y, Z, K, M}, m_drv);
    end
  end
  task automatic go(input logic md, input logic [4:0] v, output int t0);
    @(posedge clk); #2;
    bus.start = 1; bus.mode = md; bus.vec_in = v;
    @(posedge clk); #2;
    t0 = cyc;
    bus.start = 0;
  endtask
  task automatic wait_done(input int lim, input int t0, output int lat);
    lat = -1;
    for (int k = 0; k < lim; k++) begin
      if (bus.done) begin lat = cyc - t0; break; end
      @(posedge clk); #2;
    end
  endtask
  initial begin : stim
    int t0, lat, nd, n1, n4, l1, l4;
    bus.start = 0; bus.mode = 0; bus.vec_in = 0;
    b1.start = 0; b1.mode = 0; b1.vec_in = 0;
    b4.start = 0; b4.mode = 0; b4.vec_in = 0;
    repeat (5) @(posedge clk);
    #2;
    chk("reset_busy", bus.busy, 0);
    chk("reset_table", bus.table_out, 0);
    reset = 0;
    sel = 0;
    go(1, 0, t0);
    wait_done(300, t0, lat);
    chk("sweep_stub_latency", lat, 32 * P + 1);
    chk("sweep_stub_table", bus.table_out, 32'hAAAA_AAAA);
    chk("sweep_stub_ones", bus.ones_count, 16);
    sel = 1;
    go(1, 0, t0);
    wait_done(300, t0, lat);
    chk("sweep_sop_latency", lat, 32 * P + 1);
    chk("sweep_sop_table", bus.table_out, 32'h0A3E_8C4C);
    chk("sweep_sop_ones", bus.ones_count, 13);
    go(0, 5'd20, t0);
    wait_done(30, t0, lat);
    chk("single20_latency", lat, S + 3);
    chk("single20_result", bus.result, 1);
    chk("single20_table_kept", bus.table_out, 32'h0A3E_8C4C);
    chk("single20_ones_kept", bus.ones_count, 13);
    chk("single20_drive", {X, Y, Z, K, M}, 20);
    go(0, 5'd0, t0);
    wait_done(30, t0, lat);
    chk("single0_result", bus.result, 0);
    go(0, 5'd3, t0);
    wait_done(30, t0, lat);
    chk("single3_result", bus.result, 1);
    bus.start = 1; bus.mode = 0; bus.vec_in = 5'd7;
    @(posedge clk); #2;
    bus.start = 0;
    chk("start_at_done_busy", bus.busy, 0);
    repeat (8) @(posedge clk);
    #2;
    chk("start_at_done_drive", {X, Y, Z, K, M}, 3);
    sel = 0;
    go(1, 0, t0);
    repeat (40) @(posedge clk);
    #2;
    bus.start = 1; bus.mode = 0; bus.vec_in = 5'd5;
    @(posedge clk); #2;
    bus.start = 0;
    nd = 0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #2;
      if (bus.done) nd++;
    end
    chk("busy_start_done_count", nd, 1);
    chk("busy_start_table", bus.table_out, 32'hAAAA_AAAA);
    chk("busy_start_last_drive", {X, Y, Z, K, M}, 31);
    go(1, 0, t0);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if ({X, Y, Z, K, M} == 5'd9) break;
    end
    chk("reached_vector9", {X, Y, Z, K, M}, 9);
    reset = 1;
    @(posedge clk); #2;
    reset = 0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_table", bus.table_out, 0);
    chk("abort_ones", bus.ones_count, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_drive", {X, Y, Z, K, M}, 0);
    nd = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (bus.done) nd++;
    end
    chk("abort_no_done", nd, 0);
    @(posedge clk); #2;
    b1.start = 1; b1.mode = 1; b4.start = 1; b4.mode = 1;
    @(posedge clk); #2;
    t0 = cyc;
    b1.start = 0; b4.start = 0;
    n1 = 0; n4 = 0; l1 = -1; l4 = -1;
    for (int k = 0; k < 400; k++) begin
      if (b1.done) begin n1++; l1 = cyc - t0; end
      if (b4.done) begin n4++; l4 = cyc - t0; end
      @(posedge clk); #2;
    end
    chk("settle1_latency", l1, 32 * 3 + 1);
    chk("settle4_latency", l4, 32 * 6 + 1);
    chk("settle1_done_count", n1, 1);
    chk("settle4_done_count", n4, 1);
    chk("settle1_table", b1.table_out, 32'hAAAA_AAAA);
    chk("settle4_table", b4.table_out, 32'hAAAA_AAAA);
    chk("settle1_ones", b1.ones_count, 16);
    chk("settle4_ones", b4.ones_count, 16);
    chk("settle1_last_drive", {X1, Y1, Z1, K1, M1}, 31);
    chk("settle4_last_drive", {X4, Y4, Z4, K4, M4}, 31);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
